// File: rtl/key_event_scheduler_if.sv
// Event port bundle: one classified key event per valid/ready handshake,
// plus a single-cycle overflow pulse.
interface key_event_scheduler_if #(
  parameter int unsigned IDX_W = 2
);
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_key;
  logic [1:0]       evt_type;
  logic             evt_overflow;

  modport master (
    output evt_valid, evt_key, evt_type, evt_overflow,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_key, evt_type, evt_overflow,
    output evt_ready
  );
endinterface

// File: rtl/key_event_scheduler.sv
// Classifies debounced key levels into SHORT/LONG events (REPEAT too when
// KEY_EVT_REPEAT_EN is defined) and serialises them round-robin onto one port.
module key_event_scheduler #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned IDX_W      = 2,
  parameter int unsigned CNT_W      = 26,
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      key_lvl,
  key_event_scheduler_if.master evt
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD} state_t;

  localparam logic [1:0]       TYPE_SHORT = 2'b01;
  localparam logic [1:0]       TYPE_LONG  = 2'b10;
  localparam logic [CNT_W-1:0] LONG_TC    = CNT_W'(LONG_CYC - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [1:0]       TYPE_REP   = 2'b11;
  localparam logic [CNT_W-1:0] REP_TC     = CNT_W'(REPEAT_CYC - 1);
`endif

  if ((WIDTH > (32'd1 << IDX_W)) || (LONG_CYC < 1) || (REPEAT_CYC < 1) ||
      (((LONG_CYC - 1) >> CNT_W) != 0) || (((REPEAT_CYC - 1) >> CNT_W) != 0)) begin : g_param_err
    $error("key_event_scheduler: IDX_W/CNT_W too narrow for WIDTH/LONG_CYC/REPEAT_CYC");
  end

  logic [WIDTH-1:0] r_key_d;
  state_t           r_state [WIDTH];
  logic [CNT_W-1:0] r_cnt   [WIDTH];
  logic [WIDTH-1:0] r_pend;
  logic [1:0]       r_pend_type [WIDTH];
  logic [IDX_W-1:0] r_rr;
  logic             r_valid;
  logic [IDX_W-1:0] r_key;
  logic [1:0]       r_type;
  logic             r_ovf;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  state_t           w_state_nxt [WIDTH];
  logic [CNT_W-1:0] w_cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] w_post;
  logic [1:0]       w_post_type [WIDTH];
  logic             w_load;
  logic             w_found;
  logic [IDX_W-1:0] w_scan;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt;

  assign w_rise = key_lvl & ~r_key_d;
  assign w_fall = ~key_lvl & r_key_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_d <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_key_d <= key_lvl;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        ST_IDLE:  if (w_rise[i]) w_state_nxt[i] = ST_PRESS;
        ST_PRESS: begin
          if (r_cnt[i] == LONG_TC) w_state_nxt[i] = w_fall[i] ? ST_IDLE : ST_HELD;
          else if (w_fall[i])      w_state_nxt[i] = ST_IDLE;
        end
        ST_HELD:  if (w_fall[i]) w_state_nxt[i] = ST_IDLE;
        default:  w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // Terminal count wins over a coincident release, so such a press reports LONG.
  always_comb begin
    w_post = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_post_type[i] = '0;
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        ST_IDLE: w_cnt_nxt[i] = '0;
        ST_PRESS: begin
          if (r_cnt[i] == LONG_TC) begin
            w_post[i]      = 1'b1;
            w_post_type[i] = TYPE_LONG;
            w_cnt_nxt[i]   = '0;
          end else if (w_fall[i]) begin
            w_post[i]      = 1'b1;
            w_post_type[i] = TYPE_SHORT;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
        end
        ST_HELD: begin
`ifdef KEY_EVT_REPEAT_EN
          if (w_fall[i]) begin
            w_cnt_nxt[i] = '0;
          end else if (r_cnt[i] == REP_TC) begin
            w_post[i]      = 1'b1;
            w_post_type[i] = TYPE_REP;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 1'b1;
          end
`else
          w_cnt_nxt[i] = '0;
`endif
        end
        default: w_cnt_nxt[i] = '0;
      endcase
    end
  end

  assign w_load = !r_valid || evt.evt_ready;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned off = 1; off <= WIDTH; off++) begin
      w_scan = IDX_W'((32'(r_rr) + off) % WIDTH);
      if (!w_found && r_pend[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_load && w_found) w_gnt[w_gnt_idx] = 1'b1;
  end

  // A post landing on the key being granted keeps the new event pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) r_pend_type[i] <= '0;
    end else begin
      r_ovf <= |(w_post & r_pend & ~w_gnt);
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (w_post[i]) begin
          r_pend[i]      <= 1'b1;
          r_pend_type[i] <= w_post_type[i];
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_key   <= '0;
      r_type  <= '0;
      r_rr    <= IDX_W'(WIDTH - 1);
    end else if (w_load) begin
      if (w_found) begin
        r_valid <= 1'b1;
        r_key   <= w_gnt_idx;
        r_type  <= r_pend_type[w_gnt_idx];
        r_rr    <= w_gnt_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt.evt_valid    = r_valid;
  assign evt.evt_key      = r_key;
  assign evt.evt_type     = r_type;
  assign evt.evt_overflow = r_ovf;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: press-duration reference model with
// round-robin pending table, checked every cycle, plus literal event checks.
`timescale 1ns/1ps
module tb_key_event_scheduler;
  localparam int W    = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
`ifdef KEY_EVT_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [W-1:0] key_lvl = '0;

  key_event_scheduler_if #(.IDX_W(2)) bus ();

  key_event_scheduler #(
    .WIDTH(W), .IDX_W(2), .CNT_W(8), .LONG_CYC(LONG), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .evt(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int key; int ty; } ev_t;
  ev_t evq[$];

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // model state: a key is "pressed" from its rise edge; age = edges since rise
  bit m_prev [W];
  bit m_pressed [W];
  int m_rise [W];
  int m_pend [W];
  int m_rr;
  bit m_valid;
  int m_key;
  int m_type;
  bit m_ovf;
  int ovf_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, t);
    end
  endtask

  task automatic chk_ev(string nm, int idx, int te, int ke, int ye);
    if (evq.size() <= idx) begin
      total++; bad++;
      $display("FAIL %s: only %0d events, want entry %0d", nm, evq.size(), idx);
    end else begin
      chk({nm, ".t"},   evq[idx].t,   te);
      chk({nm, ".key"}, evq[idx].key, ke);
      chk({nm, ".type"}, evq[idx].ty, ye);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_prev[i] = 0; m_pressed[i] = 0; m_rise[i] = 0; m_pend[i] = 0;
    end
    m_rr = W - 1; m_valid = 0; m_key = 0; m_type = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int post [W];
    int age;
    int g;
    for (int i = 0; i < W; i++) begin
      post[i] = 0;
      if (m_pressed[i]) begin
        age = t - m_rise[i];
        if (age == LONG) begin
          post[i] = 2;
          if (!key_lvl[i]) m_pressed[i] = 0;
        end else if (!key_lvl[i]) begin
          if (age < LONG) post[i] = 1;
          m_pressed[i] = 0;
        end else if (REP_ON && age > LONG && (age - LONG) % REP == 0) begin
          post[i] = 3;
        end
      end else if (key_lvl[i] && !m_prev[i]) begin
        m_pressed[i] = 1;
        m_rise[i]    = t;
      end
      m_prev[i] = key_lvl[i];
    end
    m_ovf = 0;
    if (!m_valid || bus.evt_ready) begin
      g = -1;
      for (int off = 1; off <= W; off++)
        if (g < 0 && m_pend[(m_rr + off) % W] != 0) g = (m_rr + off) % W;
      if (g >= 0) begin
        m_valid = 1; m_key = g; m_type = m_pend[g]; m_pend[g] = 0; m_rr = g;
      end else begin
        m_valid = 0;
      end
    end
    for (int i = 0; i < W; i++)
      if (post[i] != 0) begin
        if (m_pend[i] != 0) begin m_ovf = 1; ovf_cnt++; end
        m_pend[i] = post[i];
      end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin model_step(); t++; end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("valid", bus.evt_valid, m_valid);
      if (m_valid) begin
        chk("key", bus.evt_key, m_key[1:0]);
        chk("type", bus.evt_type, m_type[1:0]);
      end
      chk("overflow", bus.evt_overflow, m_ovf);
      if (m_valid && bus.evt_ready) evq.push_back('{t - 1, m_key, m_type});
    end
  end

  task automatic hold_key(int k, int n, output int rise, output int fall);
    @(posedge clk); #1;
    rise = t; key_lvl[k] = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    fall = t; key_lvl[k] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; key_lvl = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
  endtask

  int r, f, o0, tr;

  initial begin
    bus.evt_ready = 1'b1;
    #1;
    chk("rst.valid", bus.evt_valid, 0);
    chk("rst.key",   bus.evt_key, 0);
    chk("rst.type",  bus.evt_type, 0);
    chk("rst.ovf",   bus.evt_overflow, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // short press on key1
    evq.delete(); o0 = ovf_cnt;
    hold_key(1, 5, r, f);
    idle(6);
    chk("short.count", evq.size(), 1);
    chk_ev("short", 0, f + 1, 1, 1);
    chk("short.ovf", ovf_cnt - o0, 0);

    // long hold on key0
    evq.delete();
    if (REP_ON) begin
      hold_key(0, 40, r, f);
      idle(6);
      chk("rep.count", evq.size(), 3);
      chk_ev("rep.long", 0, r + 21, 0, 2);
      chk_ev("rep.r1",   1, r + 29, 0, 3);
      chk_ev("rep.r2",   2, r + 37, 0, 3);
    end else begin
      hold_key(0, 30, r, f);
      idle(6);
      chk("long.count", evq.size(), 1);
      chk_ev("long", 0, r + 21, 0, 2);
    end

    // round-robin from reset pointer, then wrap from rr=3
    do_reset();
    evq.delete();
    @(posedge clk); #1 key_lvl = 4'b1101;
    repeat (4) @(posedge clk);
    #1 f = t; key_lvl = '0;
    idle(6);
    chk("rr1.count", evq.size(), 3);
    chk_ev("rr1.a", 0, f + 1, 0, 1);
    chk_ev("rr1.b", 1, f + 2, 2, 1);
    chk_ev("rr1.c", 2, f + 3, 3, 1);
    evq.delete();
    @(posedge clk); #1 key_lvl = 4'b1001;
    repeat (3) @(posedge clk);
    #1 f = t; key_lvl = '0;
    idle(6);
    chk("rr2.count", evq.size(), 2);
    chk_ev("rr2.a", 0, f + 1, 0, 1);
    chk_ev("rr2.b", 1, f + 2, 3, 1);

    // backpressure: three shorts on key2 with ready low
    @(posedge clk); #1 bus.evt_ready = 1'b0;
    o0 = ovf_cnt;
    hold_key(2, 3, r, f);
    hold_key(2, 3, r, f);
    hold_key(2, 3, r, f);
    idle(4);
    chk("bp.ovf", ovf_cnt - o0, 1);
    chk("bp.mkey", m_key, 2);
    chk("bp.mtype", m_type, 1);
    evq.delete();
    @(posedge clk); #1 bus.evt_ready = 1'b1;
    idle(8);
    chk("bp.count", evq.size(), 2);
    if (evq.size() == 2) begin
      chk("bp.k0", evq[0].key, 2);
      chk("bp.k1", evq[1].key, 2);
    end

    // reset mid-press with a pending event
    @(posedge clk); #1 bus.evt_ready = 1'b0;
    hold_key(1, 3, r, f);
    hold_key(3, 3, r, f);
    @(posedge clk); #1 key_lvl[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid.valid", bus.evt_valid, 0);
    chk("mid.key",   bus.evt_key, 0);
    chk("mid.type",  bus.evt_type, 0);
    chk("mid.ovf",   bus.evt_overflow, 0);
    repeat (3) @(posedge clk);
    #1 bus.evt_ready = 1'b1; rst_n = 1'b1; tr = t;
    evq.delete();
    repeat (25) @(posedge clk);
    #1 key_lvl[0] = 1'b0;
    idle(6);
    chk("mid.count", evq.size(), 1);
    chk_ev("mid.long", 0, tr + 21, 0, 2);

    // randomized presses and backpressure
    repeat (3000) begin
      @(posedge clk); #1;
      for (int k = 0; k < W; k++)
        if ($urandom_range(0, 99) < (key_lvl[k] ? 4 : 10)) key_lvl[k] = ~key_lvl[k];
      bus.evt_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 key_lvl = '0; bus.evt_ready = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
